util_pulse_gen: RTL and testbench
=================================

Name: util_pulse_gen

Overview:
- Generates a configurable train of rectangular pulses with programmable high time, low time and pulse count.
- Transmit-side counterpart of the team's high/low-time glitch filter. It drives test stimulus and control strobes whose widths a downstream filter with matching thresholds accepts or rejects.
- Sits in utils; controlled from a register bank (start/stop strobes, cfg words) in the single clk domain.

Parameters:
- CNT_WIDTH, 32, width of cfg_high_time, cfg_low_time and the internal phase counter.
- NUM_WIDTH, 32, width of cfg_pulse_num and pulse_cnt.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- cfg_high_time  in  CNT_WIDTH  high phase length in clk cycles; 0 treated as 1
- cfg_low_time  in  CNT_WIDTH  low phase length in clk cycles; 0 treated as 1
- cfg_pulse_num  in  NUM_WIDTH  pulses per run; 0 = continuous until stop
- start  in  1  single-cycle strobe, begins a run
- stop  in  1  single-cycle strobe, aborts a run
- pulse_o  out  1  generated waveform (registered)
- busy  out  1  high while a run is active
- done  out  1  one-cycle strobe at run end (normal or aborted)
- pulse_cnt  out  NUM_WIDTH  completed high phases in the current/last run

Behaviour:
- Reset (rstn=0, asynchronous): state IDLE, pulse_o=0, busy=0, done=0, pulse_cnt=0, counters 0.
- Release of rstn is synchronous to clk.
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - On start=1 with stop=0: latch all three cfg values, clear pulse_cnt, go to HIGH.
  - Next cycle: pulse_o=1, busy=1. Latency from start to first pulse_o edge is 1 cycle.
- HIGH:
  - pulse_o=1 for exactly max(high,1) cycles.
  - On the last cycle: pulse_cnt+1, go to LOW.
- LOW:
  - pulse_o=0 for exactly max(low,1) cycles. Every pulse, including the last, is followed by a full low phase.
  - On the last cycle, if pulse_num!=0 and pulse_cnt==pulse_num: go to IDLE, done=1 for one cycle, busy=0 in the same cycle as done. Otherwise go to HIGH.
- Latched config: cfg changes during a run have no effect until the next start.
- Phase counter: down-counter loaded with max(cfg,1)-1, transitions at 0. No wrap; a value of 2^CNT_WIDTH-1 is legal.
- Continuous mode (pulse_num=0): runs until stop. pulse_cnt saturates at all-ones and does not wrap.
- stop in HIGH or LOW:
  - Next cycle: pulse_o=0, state IDLE, busy=0, done=1.
  - pulse_cnt holds its value; a truncated high phase is not counted.
- stop and start in the same IDLE cycle: stop wins, no run starts, done stays 0.
- stop in IDLE alone: no effect.
- start while busy: ignored, no restart.
- stop on the final LOW cycle: done is asserted once, not twice.
- done is combinational-free (registered) and never coincides with busy=1.

Optional Feature:
- Macro: UTIL_PULSE_GEN_INVERT_EN.
- Defined:
  - Adds input port cfg_invert (1 bit), latched on start together with the other cfg values.
  - When the latched value is 1, pulse_o is active-low: idle/reset level 1, HIGH state drives 0, LOW state drives 1.
  - Reset value of pulse_o becomes 1 only if cfg_invert is sampled 1 at reset. Since reset is asynchronous, pulse_o resets to 0 and adopts the inverted idle level on the first clock after rstn release.
- Not defined: no port; behaviour exactly as above.

Decomposition:
- Shared utils package: state encoding typedef (IDLE/HIGH/LOW) and a localparam/function for the "0 treated as 1" length clamp. The clamp is reused by util_filter-compatible blocks.
- One natural sub-module: util_phase_timer, a loadable down-counter with a zero flag. It is instantiated once and time-shared between the HIGH and LOW phases.
- All other logic stays flat in util_pulse_gen.

Test Plan:
- high=3, low=2, num=4, start → pulse_o pattern 111 00 repeated 4 times, starting 1 cycle after start. Then done=1 for one cycle, pulse_cnt=4, busy=0.
- high=0, low=0, num=3 → 101010 (each phase 1 cycle), done after 6 busy cycles, pulse_cnt=3.
- num=0, high=2, low=2, stop issued at cycle 9 after start → continuous 1100 pattern until stop. Then pulse_o=0 next cycle, done=1, pulse_cnt=2 (third pulse truncated, not counted).
- Start and stop asserted together in IDLE → busy stays 0, done stays 0. Start pulsed again mid-run → waveform unchanged.
- Change cfg_high_time from 3 to 7 mid-run → current run keeps 3-cycle highs. The next start uses 7.
- Drop rstn mid-HIGH → pulse_o, busy, done 0 immediately (asynchronously). After release with no start, outputs remain idle.
- With UTIL_PULSE_GEN_INVERT_EN and cfg_invert=1 → idle level 1, and the pulses above appear inverted.

Source files
------------

// File: rtl/util_pulse_gen_pkg.sv
// util_pulse_gen_pkg: state encoding and length helpers for the pulse generator
// and its companion blocks.
// The "0 counts as 1" length rule lives here so every block that shares
// thresholds with the pulse generator applies it the same way.
package util_pulse_gen_pkg;

  // Widest phase length the helper functions accept. Narrower callers
  // widen with a sized cast and truncate the result back.
  localparam int unsigned UTIL_MAX_LEN_WIDTH = 64;

  // Smallest phase length that can be produced.
  localparam logic [UTIL_MAX_LEN_WIDTH-1:0] UTIL_MIN_LEN = UTIL_MAX_LEN_WIDTH'(1);

  // Generator state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pulse_state_e;

  // A configured length of zero is treated as one cycle.
  function automatic logic [UTIL_MAX_LEN_WIDTH-1:0] clamp_len(
    input logic [UTIL_MAX_LEN_WIDTH-1:0] len
  );
    clamp_len = (len == '0) ? UTIL_MIN_LEN : len;
  endfunction

  // Value loaded into a down-counter that hits zero on the final cycle of a
  // phase lasting clamp_len(len) cycles.
  function automatic logic [UTIL_MAX_LEN_WIDTH-1:0] phase_reload(
    input logic [UTIL_MAX_LEN_WIDTH-1:0] len
  );
    phase_reload = clamp_len(len) - UTIL_MIN_LEN;
  endfunction

endpackage

// File: rtl/util_phase_timer.sv
// util_phase_timer: loadable down-counter with a zero flag.
// The pulse generator loads it at the start of each phase. The zero flag then
// marks the last cycle of that phase. It stops at zero instead of wrapping,
// so an all-ones load value is a legal length.
module util_phase_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load has priority. Otherwise count down while enabled and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/util_pulse_gen.sv
// util_pulse_gen: programmable train of rectangular pulses.
// Each pulse has a high phase followed by a full low phase. The run ends after
// cfg_pulse_num pulses, or runs continuously when that value is zero, until
// stop is asserted. All outputs are registered. Configuration is latched on
// start, so a run is immune to register-bank writes made while it is active.
// Optional feature macro: UTIL_PULSE_GEN_INVERT_EN adds cfg_invert. When set,
// it makes pulse_o active-low for the run it is latched with. While idle, the
// idle level follows cfg_invert.
module util_pulse_gen #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned NUM_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [CNT_WIDTH-1:0] cfg_high_time,
  input  logic [CNT_WIDTH-1:0] cfg_low_time,
  input  logic [NUM_WIDTH-1:0] cfg_pulse_num,
  input  logic                 start,
  input  logic                 stop,
  output logic                 pulse_o,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_WIDTH-1:0] pulse_cnt
`ifdef UTIL_PULSE_GEN_INVERT_EN
  ,
  input  logic                 cfg_invert
`endif
);

  import util_pulse_gen_pkg::*;

  pulse_state_e         state_q,     state_d;
  logic [CNT_WIDTH-1:0] high_q,      high_d;
  logic [CNT_WIDTH-1:0] low_q,       low_d;
  logic [NUM_WIDTH-1:0] num_q,       num_d;
  logic [NUM_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
  logic                 pulse_q,     pulse_d;
  logic                 busy_q,      busy_d;
  logic                 done_q,      done_d;
  logic                 invert_d;

  logic                 timer_load;
  logic                 timer_en;
  logic [CNT_WIDTH-1:0] timer_load_val;
  logic                 timer_zero;

  logic [CNT_WIDTH-1:0] start_high_reload;
  logic [CNT_WIDTH-1:0] high_reload;
  logic [CNT_WIDTH-1:0] low_reload;
  logic [NUM_WIDTH-1:0] pulse_cnt_inc;

  // One timer serves both phases. It is reloaded at every phase boundary.
  util_phase_timer #(
    .WIDTH(CNT_WIDTH)
  ) u_phase_timer (
    .clk       (clk),
    .rstn      (rstn),
    .load_i    (timer_load),
    .en_i      (timer_en),
    .load_val_i(timer_load_val),
    .zero_o    (timer_zero)
  );

  assign start_high_reload =
    CNT_WIDTH'(phase_reload(UTIL_MAX_LEN_WIDTH'(cfg_high_time)));
  assign high_reload =
    CNT_WIDTH'(phase_reload(UTIL_MAX_LEN_WIDTH'(high_q)));
  assign low_reload =
    CNT_WIDTH'(phase_reload(UTIL_MAX_LEN_WIDTH'(low_q)));

  // Completed pulses saturate rather than wrap in long continuous runs.
  assign pulse_cnt_inc = (pulse_cnt_q == '1) ? pulse_cnt_q
                                             : pulse_cnt_q + NUM_WIDTH'(1);

  assign timer_en = (state_q != IDLE);

  // Next state, latched config, pulse counting and phase timer control.
  // stop has priority over every phase-end transition, so a stop on the final
  // low cycle still yields a single done strobe.
  always_comb begin
    state_d        = state_q;
    high_d         = high_q;
    low_d          = low_q;
    num_d          = num_q;
    pulse_cnt_d    = pulse_cnt_q;
    done_d         = 1'b0;
    timer_load     = 1'b0;
    timer_load_val = '0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          high_d         = cfg_high_time;
          low_d          = cfg_low_time;
          num_d          = cfg_pulse_num;
          pulse_cnt_d    = '0;
          timer_load     = 1'b1;
          timer_load_val = start_high_reload;
          state_d        = HIGH;
        end
      end
      HIGH: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (timer_zero) begin
          pulse_cnt_d    = pulse_cnt_inc;
          timer_load     = 1'b1;
          timer_load_val = low_reload;
          state_d        = LOW;
        end
      end
      LOW: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (timer_zero) begin
          if ((num_q != '0) && (pulse_cnt_q == num_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            timer_load     = 1'b1;
            timer_load_val = high_reload;
            state_d        = HIGH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef UTIL_PULSE_GEN_INVERT_EN
  logic invert_q;

  // While idle, the polarity tracks cfg_invert, which also latches it on start.
  // During a run, the polarity stays fixed at the value latched on start.
  always_comb begin
    invert_d = invert_q;
    if (state_q == IDLE) begin
      invert_d = cfg_invert;
    end
  end

  // Polarity register. After reset it takes the idle level on the first clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      invert_q <= 1'b0;
    end else begin
      invert_q <= invert_d;
    end
  end
`else
  assign invert_d = 1'b0;
`endif

  // Output levels follow the state being entered, so they change together with it.
  always_comb begin
    pulse_d = (state_d == HIGH) ^ invert_d;
    busy_d  = (state_d != IDLE);
  end

  // State, latched config and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      high_q      <= '0;
      low_q       <= '0;
      num_q       <= '0;
      pulse_cnt_q <= '0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      high_q      <= high_d;
      low_q       <= low_d;
      num_q       <= num_d;
      pulse_cnt_q <= pulse_cnt_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pulse_o   = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_util_pulse_gen.sv
// tb_util_pulse_gen: directed test of util_pulse_gen with hand-derived
// expected waveforms. Define UTIL_PULSE_GEN_INVERT_EN to also run the
// inverted-polarity steps.
module tb_util_pulse_gen;

  logic        clk;
  logic        rstn;
  logic [31:0] cfgHighTime;
  logic [31:0] cfgLowTime;
  logic [31:0] cfgPulseNum;
  logic        start;
  logic        stop;
  logic        pulseO;
  logic        busy;
  logic        done;
  logic [31:0] pulseCnt;
`ifdef UTIL_PULSE_GEN_INVERT_EN
  logic        cfgInvert;
`endif

  int   vecs;
  int   miscompares;
  logic inv;

  util_pulse_gen #(
    .CNT_WIDTH(32),
    .NUM_WIDTH(32)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cfg_high_time(cfgHighTime),
    .cfg_low_time (cfgLowTime),
    .cfg_pulse_num(cfgPulseNum),
    .start        (start),
    .stop         (stop),
    .pulse_o      (pulseO),
    .busy         (busy),
    .done         (done),
    .pulse_cnt    (pulseCnt)
`ifdef UTIL_PULSE_GEN_INVERT_EN
    ,
    .cfg_invert   (cfgInvert)
`endif
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the strobes for exactly one clock edge, then release them.
  task automatic applyStimulus(input logic st, input logic sp);
    start = st;
    stop  = sp;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Compare all outputs. The expected pulse level is given active-high and
  // is flipped when the inverted polarity is active.
  task automatic checkOutput(input string tag, input logic expPulse,
                             input logic expBusy, input logic expDone,
                             input int expCnt);
    logic [34:0] obs;
    logic [34:0] exp;
    obs = {pulseO, busy, done, pulseCnt};
    exp = {expPulse ^ inv, expBusy, expDone, 32'(expCnt)};
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: pulse_o=%b busy=%b done=%b cnt=%0d, expected pulse_o=%b busy=%b done=%b cnt=%0d",
             tag, pulseO, busy, done, pulseCnt, expPulse ^ inv, expBusy, expDone, expCnt);
    end
  endtask

  // Start a run and follow it to completion. hEff and lEff are the phase
  // lengths after the zero-as-one clamp. If pokeAt >= 0, then at that sample
  // cfg_high_time is rewritten to pokeHigh and start is pulsed again. Neither
  // change may alter the waveform of the run in progress.
  task automatic runTrain(input string tag, input int h, input int l,
                          input int hEff, input int lEff, input int n,
                          input int pokeAt, input int pokeHigh);
    int period;
    int pos;
    period      = hEff + lEff;
    cfgHighTime = 32'(h);
    cfgLowTime  = 32'(l);
    cfgPulseNum = 32'(n);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < period * n; i++) begin
      pos = i % period;
      checkOutput(tag, pos < hEff, 1'b1, 1'b0, i / period + ((pos >= hEff) ? 1 : 0));
      if (i == pokeAt) begin
        cfgHighTime = 32'(pokeHigh);
      end
      applyStimulus(i == pokeAt, 1'b0);
    end
    checkOutput({tag, "_done"}, 1'b0, 1'b0, 1'b1, n);
    tick();
    checkOutput({tag, "_after"}, 1'b0, 1'b0, 1'b0, n);
  endtask

  initial begin
    vecs        = 0;
    miscompares = 0;
    inv         = 1'b0;
    rstn        = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    cfgHighTime = '0;
    cfgLowTime  = '0;
    cfgPulseNum = '0;
`ifdef UTIL_PULSE_GEN_INVERT_EN
    cfgInvert   = 1'b0;
`endif

    #3;
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    checkOutput("post_reset", 1'b0, 1'b0, 1'b0, 0);

    // Pattern 11100 four times, then done with count 4.
    runTrain("h3l2n4", 3, 2, 3, 2, 4, -1, 0);

    // Zero lengths act as one cycle: pattern 101010.
    runTrain("h0l0n3", 0, 0, 1, 1, 3, -1, 0);

    // Continuous 1100 pattern. stop lands on the first high cycle of pulse 3.
    cfgHighTime = 32'd2;
    cfgLowTime  = 32'd2;
    cfgPulseNum = 32'd0;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      checkOutput("cont", (i % 4) < 2, 1'b1, 1'b0, i / 4 + (((i % 4) >= 2) ? 1 : 0));
      applyStimulus(1'b0, i == 8);
    end
    checkOutput("cont_stop", 1'b0, 1'b0, 1'b1, 2);
    tick();
    checkOutput("cont_after", 1'b0, 1'b0, 1'b0, 2);

    // start together with stop in IDLE: stop wins.
    applyStimulus(1'b1, 1'b1);
    checkOutput("start_stop_idle", 1'b0, 1'b0, 1'b0, 2);
    // stop alone in IDLE has no effect.
    applyStimulus(1'b0, 1'b1);
    checkOutput("stop_idle", 1'b0, 1'b0, 1'b0, 2);

    // stop on the final low cycle gives exactly one done.
    cfgHighTime = 32'd1;
    cfgLowTime  = 32'd1;
    cfgPulseNum = 32'd1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("last_low_high", 1'b1, 1'b1, 1'b0, 0);
    tick();
    checkOutput("last_low_low", 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("last_low_done", 1'b0, 1'b0, 1'b1, 1);
    tick();
    checkOutput("last_low_once", 1'b0, 1'b0, 1'b0, 1);

    // A mid-run cfg write plus a restart attempt leaves the 3-cycle highs intact.
    runTrain("midrun", 3, 2, 3, 2, 2, 2, 7);
    // The next run picks up the new high time.
    runTrain("newcfg", 7, 2, 7, 2, 1, -1, 7);

    // Asynchronous reset in the middle of a high phase.
    cfgHighTime = 32'd5;
    cfgLowTime  = 32'd2;
    cfgPulseNum = 32'd2;
    applyStimulus(1'b1, 1'b0);
    tick();
    checkOutput("pre_async_rst", 1'b1, 1'b1, 1'b0, 0);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_rst", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tick();
    checkOutput("rst_idle", 1'b0, 1'b0, 1'b0, 0);

`ifdef UTIL_PULSE_GEN_INVERT_EN
    // Inverted polarity: idle level 1, and the pulses appear as low pulses.
    cfgInvert = 1'b1;
    inv       = 1'b1;
    tick();
    checkOutput("inv_idle", 1'b0, 1'b0, 1'b0, 0);
    runTrain("inv_train", 2, 1, 2, 1, 2, -1, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
